up_down_load_counter: RTL and testbench

- Synchronous, loadable, parameterised-width binary counter that counts up or down each clock.
- Wraps modulo 2^CNT_WIDTH.
- Provides terminal-value flags and a one-cycle wrap pulse.
- Used as a general-purpose counting/sequencing primitive in datapath and control logic.

---
 rtl/up_down_load_counter.sv | 58 +++++
 tb/tb_up_down_load_counter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/up_down_load_counter.sv
// Loadable up/down binary counter, wraps modulo 2^CNT_WIDTH, with terminal flags and a wrap pulse.
// Load and count steps appear on counter_out one edge after sampling; at_max/at_min decode it with no extra latency.
module up_down_load_counter #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] counter_in,
  input  logic                 up_down,
  output logic [CNT_WIDTH-1:0] counter_out,
  output logic                 at_max,
  output logic                 at_min,
  output logic                 wrap
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_wrap;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_wrap_nxt;
  logic                 w_at_max;
  logic                 w_at_min;

  assign w_at_max = (r_cnt == {CNT_WIDTH{1'b1}});
  assign w_at_min = (r_cnt == '0);

  // Load wins over counting; the boundary crossing is judged on the pre-step value.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_cnt_nxt  = counter_in;
    end else if (up_down) begin
      w_cnt_nxt  = r_cnt + 1'b1;
      w_wrap_nxt = w_at_max;
    end else begin
      w_cnt_nxt  = r_cnt - 1'b1;
      w_wrap_nxt = w_at_min;
    end
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign counter_out = r_cnt;
  assign wrap        = r_wrap;
  assign at_max      = w_at_max;
  assign at_min      = w_at_min;

endmodule

// File: tb/tb_up_down_load_counter.sv
// Directed bench for up_down_load_counter at CNT_WIDTH=3 with hand-computed expectations.
module tb_up_down_load_counter;

  localparam int W = 3;

  logic         clk;
  logic         reset_n;
  logic         load;
  logic [W-1:0] counter_in;
  logic         up_down;
  logic [W-1:0] counter_out;
  logic         at_max;
  logic         at_min;
  logic         wrap;

  int n_checks = 0;
  int n_fail   = 0;

  up_down_load_counter #(.CNT_WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .counter_in (counter_in),
    .up_down    (up_down),
    .counter_out(counter_out),
    .at_max     (at_max),
    .at_min     (at_min),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Checks the full observable state against an expected count and wrap bit.
  task automatic chk_state(input string tag, input int exp_cnt, input logic exp_wrap);
    chk({tag, ".cnt"},  32'(counter_out), 32'(exp_cnt));
    chk({tag, ".wrap"}, 32'(wrap),        32'(exp_wrap));
    chk({tag, ".max"},  32'(at_max),      32'(exp_cnt == 7));
    chk({tag, ".min"},  32'(at_min),      32'(exp_cnt == 0));
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_up[5];
    int exp_dn[3];
    reset_n    = 1'b1;
    load       = 1'b0;
    up_down    = 1'b0;
    counter_in = '0;
    #1;
    chk_state("reset_t0", 0, 1'b0);

    // Reset held across edges, then released at a falling edge.
    step();
    chk_state("reset_hold", 0, 1'b0);
    reset_n = 1'b0;

    step();
    chk_state("rel_dn7", 7, 1'b1);
    step();
    chk_state("rel_dn6", 6, 1'b0);
    step();
    chk_state("rel_dn5", 5, 1'b0);

    load = 1'b1; counter_in = 3'd3;
    step();
    chk_state("load3", 3, 1'b0);

    load = 1'b0; up_down = 1'b1;
    exp_up = '{4, 5, 6, 7, 0};
    for (int i = 0; i < 5; i++) begin
      step();
      chk_state($sformatf("up%0d", i), exp_up[i], (i == 4));
    end
    step();
    chk_state("up_after_wrap", 1, 1'b0);

    // Back to 0 via a load, then reverse direction across the lower boundary.
    load = 1'b1; counter_in = 3'd0;
    step();
    chk_state("load0", 0, 1'b0);
    load = 1'b0; up_down = 1'b0;
    exp_dn = '{7, 6, 5};
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("dn%0d", i), exp_dn[i], (i == 0));
    end
    step(); step(); step();
    chk_state("dn_to2", 2, 1'b0);

    load = 1'b1; counter_in = 3'd5; up_down = 1'b1;
    step();
    chk_state("load_prio", 5, 1'b0);

    load = 1'b0;
    step();
    chk_state("pre_rst6", 6, 1'b0);

    // Asynchronous clear between edges, while a load is also requested.
    #2;
    load = 1'b1; counter_in = 3'd4;
    reset_n = 1'b1;
    #1;
    chk_state("async_rst", 0, 1'b0);
    load = 1'b0;
    step();
    chk_state("rst_edge1", 0, 1'b0);
    step();
    chk_state("rst_edge2", 0, 1'b0);
    reset_n = 1'b0;
    step();
    chk_state("resume1", 1, 1'b0);
    step();
    chk_state("resume2", 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
